// File: rtl/fp_special_enc.sv
// IEEE-754 special/boundary value encoder behind a 2-entry valid/ready skid stage.
// Optional event counters are enabled with FP_SPECIAL_ENC_STATS_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | main empty, skid empty, out_vld low
// ST_ONE   | main holds the head beat, skid empty
// ST_TWO   | main and skid both full, in_rdy low
module fp_special_enc #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
`ifdef FP_SPECIAL_ENC_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_inf_cnt,
    output logic [15:0]       stat_nan_cnt,
`endif
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [2:0]        in_cls,
    input  logic [SIGN_W-1:0] in_sign,
    input  logic [EXPO_W-1:0] in_expo,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [SIGN_W-1:0] out_sign,
    output logic [EXPO_W-1:0] out_expo,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_inf,
    output logic              out_inf_pos,
    output logic              out_inf_neg,
    output logic              out_bad_cls
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [2:0] CLS_ZERO    = 3'd0;
    localparam logic [2:0] CLS_INF     = 3'd1;
    localparam logic [2:0] CLS_QNAN    = 3'd2;
    localparam logic [2:0] CLS_SNAN    = 3'd3;
    localparam logic [2:0] CLS_MAXNORM = 3'd4;
    localparam logic [2:0] CLS_MINSUB  = 3'd5;
    localparam logic [2:0] CLS_PASS    = 3'd6;

    localparam logic [EXPO_W-1:0] EXPO_MAX = '1;

    logic [1:0]        state;
    logic [EXPO_W-1:0] enc_expo;
    logic [MANT_W-1:0] enc_mant;
    logic              enc_bad;

    logic [SIGN_W-1:0] skid_sign;
    logic [EXPO_W-1:0] skid_expo;
    logic [MANT_W-1:0] skid_mant;
    logic              skid_bad;

    logic accept;
    logic drain;

    always_comb begin
        enc_expo = '0;
        enc_mant = '0;
        enc_bad  = 1'b0;
        case (in_cls)
            CLS_ZERO: begin
                enc_expo = '0;
            end
            CLS_INF: begin
                enc_expo = EXPO_MAX;
            end
            CLS_QNAN: begin
                enc_expo = EXPO_MAX;
                enc_mant[MANT_W-1] = 1'b1;
            end
            CLS_SNAN: begin
                enc_expo = EXPO_MAX;
                enc_mant[0] = 1'b1;
            end
            CLS_MAXNORM: begin
                enc_expo = EXPO_MAX - EXPO_W'(1);
                enc_mant = '1;
            end
            CLS_MINSUB: begin
                enc_mant = MANT_W'(1);
            end
            CLS_PASS: begin
                enc_expo = in_expo;
                enc_mant = in_mant;
            end
            default: begin
                // Reserved class is emitted as a quiet NaN and tagged.
                enc_expo = EXPO_MAX;
                enc_mant[MANT_W-1] = 1'b1;
                enc_bad  = 1'b1;
            end
        endcase
    end

    assign in_rdy  = (state != ST_TWO);
    assign out_vld = (state != ST_EMPTY);
    assign accept  = in_vld && in_rdy;
    assign drain   = out_vld && out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            out_sign    <= '0;
            out_expo    <= '0;
            out_mant    <= '0;
            out_bad_cls <= 1'b0;
            skid_sign   <= '0;
            skid_expo   <= '0;
            skid_mant   <= '0;
            skid_bad    <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state       <= ST_ONE;
                        out_sign    <= in_sign;
                        out_expo    <= enc_expo;
                        out_mant    <= enc_mant;
                        out_bad_cls <= enc_bad;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_sign    <= in_sign;
                        out_expo    <= enc_expo;
                        out_mant    <= enc_mant;
                        out_bad_cls <= enc_bad;
                    end else if (accept) begin
                        state     <= ST_TWO;
                        skid_sign <= in_sign;
                        skid_expo <= enc_expo;
                        skid_mant <= enc_mant;
                        skid_bad  <= enc_bad;
                    end else if (drain) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state       <= ST_ONE;
                        out_sign    <= skid_sign;
                        out_expo    <= skid_expo;
                        out_mant    <= skid_mant;
                        out_bad_cls <= skid_bad;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Inf flags come from the packed fields so PASS inputs are classified too.
    assign out_inf     = (out_expo == EXPO_MAX) && (out_mant == '0);
    assign out_inf_pos = out_inf && (out_sign == '0);
    assign out_inf_neg = out_inf && (out_sign != '0);

`ifdef FP_SPECIAL_ENC_STATS_EN
    logic out_nan;
    assign out_nan = (out_expo == EXPO_MAX) && (out_mant != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_inf_cnt <= '0;
            stat_nan_cnt <= '0;
        end else if (stat_clr) begin
            stat_inf_cnt <= '0;
            stat_nan_cnt <= '0;
        end else if (drain) begin
            if (out_inf && (stat_inf_cnt != 16'hFFFF)) stat_inf_cnt <= stat_inf_cnt + 16'd1;
            if (out_nan && (stat_nan_cnt != 16'hFFFF)) stat_nan_cnt <= stat_nan_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_special_enc.sv
module tb_fp_special_enc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [2:0]  in_cls = 3'd0;
   logic [0:0]  in_sign = 1'b0;
   logic [7:0]  in_expo = 8'h00;
   logic [22:0] in_mant = 23'h0;
   logic        out_vld;
   logic        out_rdy = 1'b1;
   logic [0:0]  out_sign;
   logic [7:0]  out_expo;
   logic [22:0] out_mant;
   logic        out_inf, out_inf_pos, out_inf_neg, out_bad_cls;
`ifdef FP_SPECIAL_ENC_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] stat_inf_cnt, stat_nan_cnt;
   int          m_inf_cnt = 0;
   int          m_nan_cnt = 0;
`endif

   int errors = 0;
   int checks = 0;

   logic [32:0] q[$];
   bit          stall_prev = 0;
   logic [32:0] hold_v;
   bit          lit_en = 0;
   logic [32:0] lit_v;
   bit          acc;

   fp_special_enc dut (
`ifdef FP_SPECIAL_ENC_STATS_EN
      .stat_clr(stat_clr),
      .stat_inf_cnt(stat_inf_cnt),
      .stat_nan_cnt(stat_nan_cnt),
`endif
      .clk(clk), .rst_n(rst_n),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_cls(in_cls), .in_sign(in_sign),
      .in_expo(in_expo), .in_mant(in_mant),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_sign(out_sign),
      .out_expo(out_expo), .out_mant(out_mant), .out_inf(out_inf),
      .out_inf_pos(out_inf_pos), .out_inf_neg(out_inf_neg), .out_bad_cls(out_bad_cls)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] model(input logic [2:0] c, input logic s,
                                         input logic [7:0] e, input logic [22:0] m);
      case (c)
         3'd0: model = {1'b0, s, 8'h00, 23'h000000};
         3'd1: model = {1'b0, s, 8'hFF, 23'h000000};
         3'd2: model = {1'b0, s, 8'hFF, 23'h400000};
         3'd3: model = {1'b0, s, 8'hFF, 23'h000001};
         3'd4: model = {1'b0, s, 8'hFE, 23'h7FFFFF};
         3'd5: model = {1'b0, s, 8'h00, 23'h000001};
         3'd6: model = {1'b0, s, e, m};
         default: model = {1'b1, s, 8'hFF, 23'h400000};
      endcase
   endfunction

   task automatic check();
      logic [32:0] obs;
      logic [32:0] e;
      logic        e_inf;
      obs = {out_bad_cls, out_sign, out_expo, out_mant};
      chk("in_rdy", in_rdy, (q.size() < 2) ? 1'b1 : 1'b0);
      chk("out_vld", out_vld, (q.size() > 0) ? 1'b1 : 1'b0);
`ifdef FP_SPECIAL_ENC_STATS_EN
      chk("stat_inf", stat_inf_cnt, m_inf_cnt[15:0]);
      chk("stat_nan", stat_nan_cnt, m_nan_cnt[15:0]);
`endif
      if (stall_prev) chk("hold", obs, hold_v);
      if (lit_en) begin
         chk("literal", obs, lit_v);
         lit_en = 0;
      end
      if (out_vld && out_rdy && q.size() > 0) begin
         e = q.pop_front();
         e_inf = (e[30:23] == 8'hFF) && (e[22:0] == 23'h0);
         chk("data", obs, e);
         chk("inf", out_inf, e_inf);
         chk("inf_pos", out_inf_pos, e_inf && !e[31]);
         chk("inf_neg", out_inf_neg, e_inf && e[31]);
`ifdef FP_SPECIAL_ENC_STATS_EN
         if (stat_clr) begin
            m_inf_cnt = 0;
            m_nan_cnt = 0;
         end else begin
            if (e_inf && m_inf_cnt < 65535) m_inf_cnt++;
            if (e[30:23] == 8'hFF && e[22:0] != 0 && m_nan_cnt < 65535) m_nan_cnt++;
         end
      end else if (stat_clr) begin
         m_inf_cnt = 0;
         m_nan_cnt = 0;
`endif
      end
      stall_prev = out_vld && !out_rdy;
      hold_v = obs;
      acc = in_vld && in_rdy;
      if (acc) q.push_back(model(in_cls, in_sign, in_expo, in_mant));
   endtask

   task automatic tick();
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] c, input logic s, input logic [7:0] e, input logic [22:0] m);
      in_vld = 1'b1; in_cls = c; in_sign = s; in_expo = e; in_mant = m;
   endtask

   task automatic directed(input logic [2:0] c, input logic s, input logic [7:0] e,
                           input logic [22:0] m, input logic [32:0] lit);
      out_rdy = 1'b1;
      drive(c, s, e, m);
      tick();
      in_vld = 1'b0;
      lit_en = 1; lit_v = lit;
      tick();
   endtask

   initial begin
      int idx;
      int cyc;
      #12;
      chk("rst_out_vld", out_vld, 1'b0);
      chk("rst_in_rdy", in_rdy, 1'b1);
      chk("rst_word", {out_bad_cls, out_sign, out_expo, out_mant}, 33'h0);
      chk("rst_flags", {out_inf, out_inf_pos, out_inf_neg}, 3'b000);
      rst_n = 1'b1;
      @(posedge clk); #1;

      directed(3'd1, 1'b0, 8'h00, 23'h0, {1'b0, 32'h7F800000});
      directed(3'd1, 1'b1, 8'h00, 23'h0, {1'b0, 32'hFF800000});
      directed(3'd2, 1'b0, 8'h00, 23'h0, {1'b0, 32'h7FC00000});
      directed(3'd3, 1'b0, 8'h00, 23'h0, {1'b0, 32'h7F800001});
      directed(3'd7, 1'b0, 8'h00, 23'h0, {1'b1, 32'h7FC00000});
      directed(3'd4, 1'b1, 8'h00, 23'h0, {1'b0, 32'hFF7FFFFF});
      directed(3'd5, 1'b0, 8'h00, 23'h0, {1'b0, 32'h00000001});
      directed(3'd0, 1'b1, 8'h00, 23'h0, {1'b0, 32'h80000000});
      directed(3'd6, 1'b0, 8'hFF, 23'h0, {1'b0, 32'h7F800000});
      directed(3'd6, 1'b1, 8'h3C, 23'h12345, {1'b0, 32'h9E012345});

      idx = 0;
      cyc = 0;
      while ((idx < 8 || q.size() > 0) && cyc < 40) begin
         out_rdy = !(cyc >= 2 && cyc <= 5);
         if (idx < 8) drive(idx[2:0], idx[0], 8'h00, 23'h0);
         else in_vld = 1'b0;
         tick();
         if (acc) idx++;
         cyc++;
      end
      in_vld = 1'b0;
      chk("bp_all_accepted", idx, 8);
      chk("bp_drained", q.size(), 0);

      out_rdy = 1'b0;
      drive(3'd1, 1'b0, 8'h00, 23'h0);
      tick();
      tick();
      in_vld = 1'b0;
      tick();
      chk("two_in_rdy", in_rdy, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_vld", out_vld, 1'b0);
      chk("arst_in_rdy", in_rdy, 1'b1);
      chk("arst_word", {out_bad_cls, out_sign, out_expo, out_mant}, 33'h0);
      chk("arst_flags", {out_inf, out_inf_pos, out_inf_neg}, 3'b000);
      q.delete();
      stall_prev = 0;
`ifdef FP_SPECIAL_ENC_STATS_EN
      m_inf_cnt = 0;
      m_nan_cnt = 0;
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      directed(3'd4, 1'b0, 8'h00, 23'h0, {1'b0, 32'h7F7FFFFF});

`ifdef FP_SPECIAL_ENC_STATS_EN
      out_rdy = 1'b1;
      drive(3'd1, 1'b0, 8'h00, 23'h0);
      tick();
      in_vld = 1'b0;
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      tick();
      chk("clr_wins", stat_inf_cnt, 16'h0);
`endif

      for (int i = 0; i < 400; i++) begin
         out_rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0)
            drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  8'($urandom), 23'($urandom));
         else
            in_vld = 1'b0;
         tick();
      end
      in_vld = 1'b0;
      out_rdy = 1'b1;
      for (int i = 0; i < 10 && q.size() > 0; i++) tick();
      chk("final_drain", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fp_special_enc.md
Name: fp_special_enc

Overview:
Encoder for IEEE-754 special and boundary values; the generating end of the inf/zero/NaN classification checks. Takes a class code plus sign and emits the packed {sign, expo, mant} fields, with inf flags in the same form the checker produces. Sits at rounding/exception finalisation in the FP datapath. Provides a valid/ready stream stage with a 2-entry skid buffer: full throughput, registered ready.

Parameters:
SIGN_W, 1, sign field width (only 1 supported)
EXPO_W, 8, exponent field width (>=2)
MANT_W, 23, mantissa field width (>=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_vld  input  1  input beat valid
in_rdy  output  1  input beat accepted when in_vld && in_rdy
in_cls  input  3  class: 0 ZERO, 1 INF, 2 QNAN, 3 SNAN, 4 MAXNORM, 5 MINSUB, 6 PASS, 7 reserved
in_sign  input  SIGN_W  requested sign
in_expo  input  EXPO_W  exponent, used only for PASS
in_mant  input  MANT_W  mantissa, used only for PASS
out_vld  output  1  output beat valid
out_rdy  input  1  downstream ready
out_sign  output  SIGN_W  packed sign
out_expo  output  EXPO_W  packed exponent
out_mant  output  MANT_W  packed mantissa
out_inf  output  1  output encodes infinity
out_inf_pos  output  1  out_inf && !out_sign
out_inf_neg  output  1  out_inf && out_sign
out_bad_cls  output  1  beat was produced from reserved class 7

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low.
- Encoding, with E = all-ones EXPO_W and M = MANT_W:
  - ZERO: expo 0, mant 0.
  - INF: expo E, mant 0.
  - QNAN: expo E, mant MSB=1, rest 0.
  - SNAN: expo E, mant LSB=1, rest 0 (never all-zero).
  - MAXNORM: expo E-1, mant all-ones.
  - MINSUB: expo 0, mant 1.
  - PASS: in_expo/in_mant copied unchanged.
  - Class 7: encodes as QNAN with out_bad_cls=1.
- Sign: out_sign = in_sign for all classes, including NaN.
- Inf flags: out_inf = (out_expo==E && out_mant==0), derived from the encoded fields. PASS with in_expo=E and in_mant=0 therefore flags inf.
- Pipeline: one output register (main) and one skid register.
  - Latency: accepted beat appears on out_* the cycle after acceptance when main is empty or draining.
  - Throughput: with out_rdy held high, one beat per cycle sustained.
- Handshake:
  - in_rdy is a register, equal to !skid_full.
  - out_vld = main_full.
  - out_* stable while out_vld && !out_rdy.
  - out_vld never drops without a transfer.
- Buffer states: EMPTY (main empty), ONE (main full, skid empty), TWO (both full).
  - EMPTY + accept -> ONE.
  - ONE + accept and out_rdy -> ONE (main replaced).
  - ONE + accept and !out_rdy -> TWO (beat into skid; in_rdy low next cycle).
  - ONE + out_rdy and no accept -> EMPTY.
  - TWO + out_rdy -> ONE (skid moves to main; in_rdy high next cycle).
  - TWO without out_rdy -> TWO.
- Simultaneous accept and drain in ONE: no bubble, no beat lost.
- Beats leave in acceptance order; no reordering or duplication.
- Reset, applied at any time including mid-transfer:
  - out_vld=0, in_rdy=1, buffers empty.
  - out_sign/expo/mant=0; out_inf, out_inf_pos, out_inf_neg, out_bad_cls = 0.
  - In-flight beats discarded.

Optional Feature:
FP_SPECIAL_ENC_STATS_EN
- Defined: adds ports stat_clr input 1, stat_inf_cnt output 16, stat_nan_cnt output 16.
  - Counters increment on each output transfer (out_vld && out_rdy) whose beat is inf, or NaN (expo E, mant!=0), respectively.
  - Counters saturate at 0xFFFF.
  - stat_clr is synchronous and wins over a same-cycle increment.
  - Counters reset to 0 on rst_n.
- Undefined: no stat ports and no counter logic; behaviour otherwise identical.

Test Plan:
- Defaults, out_rdy=1:
  - INF sign 0 -> {0,0xFF,0x000000}, out_inf_pos=1, one cycle later.
  - INF sign 1 -> 0xFF800000 packed, out_inf_neg=1.
- QNAN sign 0 -> 0x7FC00000; SNAN -> 0x7F800001; class 7 -> 0x7FC00000 with out_bad_cls=1; none flag inf.
- MAXNORM sign 1 -> 0xFF7FFFFF; MINSUB sign 0 -> 0x00000001; ZERO sign 1 -> 0x80000000; PASS expo 0xFF mant 0 -> out_inf=1.
- Backpressure, 8 back-to-back beats (classes 0..7), out_rdy low for cycles 2-5:
  - in_rdy drops only after the skid fills.
  - All 8 beats emerge in order, none lost or duplicated.
  - out_* held stable while stalled.
- Assert rst_n low while in state TWO -> out_vld=0, in_rdy=1 immediately (asynchronously); first beat after release appears with 1-cycle latency.
- With FP_SPECIAL_ENC_STATS_EN:
  - Preload stat_inf_cnt to 0xFFFE via 3 INF transfers on a forced start, then 2 more -> holds at 0xFFFF.
  - stat_clr concurrent with an INF transfer -> counter reads 0.
